// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared FSM state encoding and counter sizing for the serial subtractor
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // One spare bit so the count can hold WIDTH-1 without wrapping for any legal WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: one-bit cell computing a - b - bin, mirror of the full adder
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic borrow
);

    assign diff   = a ^ b ^ bin;
    assign borrow = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b - bin with start/busy/done handshake
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] d_sr_q, d_sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;
    logic             d, bo;

    full_subtractor u_cell (
        .a      (a_sr_q[0]),
        .b      (b_sr_q[0]),
        .bin    (brw_q),
        .diff   (d),
        .borrow (bo)
    );

    // State and datapath registers; reset clears everything, aborting any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            d_sr_q  <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            d_sr_q  <= d_sr_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
        end
    end

    // Next-state: capture operands on start, shift one bit per RUN cycle, publish on the last bit.
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        d_sr_d  = d_sr_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                d_sr_d = WIDTH'({d, d_sr_q} >> 1);
                brw_d  = bo;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d  = WIDTH'({d, d_sr_q} >> 1);
                    bout_d  = bo;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign busy = state_q != ST_IDLE;
    assign done = state_q == ST_DONE;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks of both an 8-bit and a 4-bit serial subtractor
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, bin8, bout8, busy8, done8;
    logic [7:0] a8, b8, diff8;
    logic       start4, bin4, bout4, busy4, done4;
    logic [3:0] a4, b4, diff4;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .diff(diff8), .bout(bout8), .busy(busy8), .done(done8)
    );

    serial_subtractor #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .diff(diff4), .bout(bout4), .busy(busy4), .done(done4)
    );

    // Reference: plain integer subtraction; borrow-out means the true result went negative.
    function automatic logic [8:0] model(input int w, input int a, input int b, input int bi);
        int r;
        r = a - b - bi;
        return {r < 0, 8'(r & ((1 << w) - 1))};
    endfunction

    // Launch one operation and watch a fixed window; poke re-pulses start on the 8-bit unit while busy.
    task automatic op(input bit w4, input logic [7:0] a, input logic [7:0] b, input bit bi,
                      input bit poke, output logic [7:0] d, output bit bo,
                      output int lat, output int bcnt, output int dcnt);
        int w;
        w = w4 ? 4 : 8;
        lat = -1; bcnt = 0; dcnt = 0; d = '0; bo = 1'b0;
        @(negedge clk);
        if (w4) begin a4 = a[3:0]; b4 = b[3:0]; bin4 = bi; start4 = 1'b1; end
        else begin a8 = a; b8 = b; bin8 = bi; start8 = 1'b1; end
        @(posedge clk); #1;
        start4 = 1'b0; start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
        for (int n = 0; n < w + 4; n++) begin
            if (n > 0) begin @(posedge clk); #1; end
            if (w4 ? busy4 : busy8) bcnt++;
            if (w4 ? done4 : done8) begin
                dcnt++;
                if (lat < 0) begin
                    lat = n + 1;
                    d = w4 ? {4'h0, diff4} : diff8;
                    bo = w4 ? bout4 : bout8;
                end
            end
            if (poke) begin
                start8 = (n == 2 || n == 8);
                if (start8) begin a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b0; end
            end
        end
        start8 = 1'b0;
    endtask

    task automatic test_reset();
        start8 = 0; start4 = 0; a8 = 0; b8 = 0; bin8 = 0; a4 = 0; b4 = 0; bin4 = 0;
        rst = 1'b1;
        #1;
        total++;
        if ({diff8, bout8, busy8, done8} !== 11'h0) begin
            bad++; $display("FAIL reset8 got %h want 0", {diff8, bout8, busy8, done8});
        end
        total++;
        if ({diff4, bout4, busy4, done4} !== 7'h0) begin
            bad++; $display("FAIL reset4 got %h want 0", {diff4, bout4, busy4, done4});
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [7:0] va[4] = '{8'd100, 8'h00, 8'hFF, 8'h80};
        logic [7:0] vb[4] = '{8'd58, 8'h01, 8'hFF, 8'h7F};
        bit         vi[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] ed[4] = '{8'h2A, 8'hFF, 8'hFF, 8'h00};
        bit         eb[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0] d;
        bit bo;
        int lat, bcnt, dcnt;
        for (int i = 0; i < 4; i++) begin
            op(1'b0, va[i], vb[i], vi[i], 1'b0, d, bo, lat, bcnt, dcnt);
            total++;
            if (d !== ed[i] || bo !== eb[i]) begin
                bad++; $display("FAIL dir%0d result got %h/%b want %h/%b", i, d, bo, ed[i], eb[i]);
            end
            total++;
            if (lat != 9 || bcnt != 9 || dcnt != 1) begin
                bad++; $display("FAIL dir%0d timing got lat=%0d busy=%0d done=%0d want 9/9/1", i, lat, bcnt, dcnt);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] a, b, d;
        logic [8:0] exp;
        bit bi, bo;
        int lat, bcnt, dcnt;
        for (int i = 0; i < 30; i++) begin
            a = 8'($urandom); b = 8'($urandom); bi = 1'($urandom);
            exp = model(8, a, b, bi);
            op(1'b0, a, b, bi, 1'b0, d, bo, lat, bcnt, dcnt);
            total++;
            if ({bo, d} !== exp || lat != 9 || dcnt != 1) begin
                bad++; $display("FAIL rand %h-%h-%b got %h lat=%0d want %h lat=9", a, b, bi, {bo, d}, lat, exp);
            end
        end
    endtask

    task automatic test_hold();
        logic [7:0] d;
        bit bo;
        int lat, bcnt, dcnt;
        op(1'b0, 8'h3C, 8'h11, 1'b1, 1'b0, d, bo, lat, bcnt, dcnt);
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (diff8 !== 8'h2A || bout8 !== 1'b0 || busy8 !== 1'b0) begin
            bad++; $display("FAIL hold got %h/%b busy=%b want 2a/0 busy=0", diff8, bout8, busy8);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        bit bo;
        int lat, bcnt, dcnt;
        op(1'b0, 8'h10, 8'h01, 1'b0, 1'b1, d, bo, lat, bcnt, dcnt);
        total++;
        if (d !== 8'h0F || bo !== 1'b0) begin
            bad++; $display("FAIL ignore_start result got %h/%b want 0f/0", d, bo);
        end
        total++;
        if (dcnt != 1 || bcnt != 9 || lat != 9) begin
            bad++; $display("FAIL ignore_start timing got lat=%0d busy=%0d done=%0d want 9/9/1", lat, bcnt, dcnt);
        end
    endtask

    task automatic test_reset_abort();
        logic [7:0] d;
        bit bo;
        int lat, bcnt, dcnt, seen;
        @(negedge clk);
        a8 = 8'hF0; b8 = 8'h0F; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++;
        if ({diff8, bout8, busy8, done8} !== 11'h0) begin
            bad++; $display("FAIL abort_outputs got %h want 0", {diff8, bout8, busy8, done8});
        end
        @(negedge clk) rst = 1'b0;
        seen = 0;
        for (int n = 0; n < 14; n++) begin
            @(posedge clk); #1;
            if (done8 || busy8) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++; $display("FAIL abort_quiet got %0d busy/done cycles want 0", seen);
        end
        op(1'b0, 8'h05, 8'h03, 1'b0, 1'b0, d, bo, lat, bcnt, dcnt);
        total++;
        if (d !== 8'h02 || bo !== 1'b0 || lat != 9 || dcnt != 1) begin
            bad++; $display("FAIL abort_restart got %h/%b lat=%0d want 02/0 lat=9", d, bo, lat);
        end
    endtask

    task automatic test_exhaustive4();
        logic [7:0] d;
        logic [8:0] exp;
        bit bo;
        int lat, bcnt, dcnt;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int bi = 0; bi < 2; bi++) begin
                    exp = model(4, a, b, bi);
                    op(1'b1, 8'(a), 8'(b), 1'(bi), 1'b0, d, bo, lat, bcnt, dcnt);
                    total++;
                    if ({bo, d} !== exp || lat != 5 || bcnt != 5 || dcnt != 1) begin
                        bad++;
                        $display("FAIL w4 %0d-%0d-%0d got %h lat=%0d busy=%0d want %h lat=5 busy=5",
                                 a, b, bi, {bo, d}, lat, bcnt, exp);
                    end
                end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_back_to_back();
        test_reset_abort();
        test_exhaustive4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
